rv32i_mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I `data_path`. It decodes the fetched instruction fields and steps each instruction through FETCH/DECODE/EXEC/MEM/WB states. It drives every `data_path` control input: `en_pc`, `RegWrite`, `AluSrc`, `AluSel`, `Mem_read`, `Mem_write` and `sel_data_to_reg`. It also stalls on a data-memory ready handshake, stops on ECALL/EBREAK, traps on illegal encodings and counts retired instructions.

---
 rtl/rv32i_pkg.sv | 53 +++++
 rtl/rv32i_mc_ctrl_if.sv | 33 +++
 rtl/rv32i_mc_ctrl_alu_decoder.sv | 32 +++
 rtl/rv32i_mc_ctrl.sv | 137 +++++++++++++
 tb/tb_rv32i_mc_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: opcodes, ALU and
// writeback encodings, sequencer states and the ALU decode classes.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_MEM   = 2'd0,
    WB_ALU   = 2'd1,
    WB_PC4   = 2'd2,
    WB_UPPER = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_TRAP
  } ctrl_state_e;

  // How the ALU decoder interprets funct3/funct7_5 for a given instruction.
  typedef enum logic [1:0] {
    CLS_ADD, CLS_R, CLS_I, CLS_BR
  } alu_cls_e;

  function automatic logic is_known_opcode(input logic [6:0] op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_mc_ctrl_if.sv
// Controller <-> data_path bundle: instruction fields and memory ready in,
// all data_path control strobes and status out.
interface rv32i_mc_ctrl_if #(parameter int CNT_W = 32);
  import rv32i_pkg::*;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             mem_ready;
  logic             en_pc;
  logic             RegWrite;
  logic             AluSrc;
  alu_op_e          AluSel;
  logic             Mem_read;
  logic             Mem_write;
  wb_sel_e          sel_data_to_reg;
  logic             halted;
  logic             trap;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct3, funct7_5, mem_ready,
    output en_pc, RegWrite, AluSrc, AluSel, Mem_read, Mem_write,
           sel_data_to_reg, halted, trap, retired
  );

  modport slave (
    output opcode, funct3, funct7_5, mem_ready,
    input  en_pc, RegWrite, AluSrc, AluSel, Mem_read, Mem_write,
           sel_data_to_reg, halted, trap, retired
  );

endinterface

// File: rtl/rv32i_mc_ctrl_alu_decoder.sv
// Combinational {class, funct3, funct7_5} -> ALU operation mapping.
module alu_decoder
  import rv32i_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output alu_op_e    op_o
);

  always_comb begin
    op_o = ALU_ADD;
    case (cls_i)
      CLS_R, CLS_I: begin
        case (funct3_i)
          // funct7_5 selects SUB only for register-register ops; ADDI ignores it.
          3'b000:  op_o = (cls_i == CLS_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  op_o = ALU_SLL;
          3'b010:  op_o = ALU_SLT;
          3'b011:  op_o = ALU_SLTU;
          3'b100:  op_o = ALU_XOR;
          3'b101:  op_o = funct7_5_i ? ALU_SRA : ALU_SRL;
          3'b110:  op_o = ALU_OR;
          default: op_o = ALU_AND;
        endcase
      end
      CLS_BR:  op_o = ALU_SUB;
      default: op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32I data_path
// controls, with memory-ready stall, halt/trap states and a retire counter.
module rv32i_mc_ctrl
  import rv32i_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            reset,
  rv32i_mc_ctrl_if.master bus
);

  ctrl_state_e      state_q, state_d;
  logic [6:0]       opcode_q;
  logic [2:0]       funct3_q;
  logic             funct7_5_q;
  logic [CNT_W-1:0] retired_q;

  logic     is_load, is_store, is_branch, is_op, is_upper, is_jump;
  logic     in_alu_phase, mem_done;
  logic     en_pc_d, reg_write_d, mem_read_d, mem_write_d;
  alu_cls_e cls;
  alu_op_e  dec_op;
  wb_sel_e  wb_sel;

  assign is_load   = (opcode_q == OPC_LOAD);
  assign is_store  = (opcode_q == OPC_STORE);
  assign is_branch = (opcode_q == OPC_BRANCH);
  assign is_op     = (opcode_q == OPC_OP);
  assign is_upper  = (opcode_q == OPC_LUI) || (opcode_q == OPC_AUIPC);
  assign is_jump   = (opcode_q == OPC_JAL) || (opcode_q == OPC_JALR);
  assign mem_done  = !MEM_WAIT_EN || bus.mem_ready;

  assign cls = is_op                     ? CLS_R  :
               (opcode_q == OPC_OPIMM)   ? CLS_I  :
               is_branch                 ? CLS_BR : CLS_ADD;

  alu_decoder u_alu_decoder (
    .cls_i      (cls),
    .funct3_i   (funct3_q),
    .funct7_5_i (funct7_5_q),
    .op_o       (dec_op)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      opcode_q   <= 7'd0;
      funct3_q   <= 3'd0;
      funct7_5_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH) begin
        opcode_q   <= bus.opcode;
        funct3_q   <= bus.funct3;
        funct7_5_q <= bus.funct7_5;
      end
      if (en_pc_d) begin
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    en_pc_d     = 1'b0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_upper)                                  state_d = ST_WB;
        else if (opcode_q == OPC_SYSTEM)               state_d = ST_HALT;
        else if (!is_known_opcode(opcode_q))           state_d = ST_TRAP;
        else if (is_op && funct7_5_q &&
                 funct3_q != 3'b000 && funct3_q != 3'b101) state_d = ST_TRAP;
        else                                           state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_branch) begin
          en_pc_d = 1'b1;
          state_d = ST_FETCH;
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_read_d  = is_load;
        mem_write_d = is_store;
        // A store retires in the cycle memory accepts it, so en_pc follows mem_ready.
        if (mem_done) begin
          if (is_load) begin
            state_d = ST_WB;
          end else begin
            en_pc_d = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        reg_write_d = 1'b1;
        en_pc_d     = 1'b1;
        state_d     = ST_FETCH;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    wb_sel = WB_MEM;
    if (state_q == ST_WB) begin
      if (is_load)       wb_sel = WB_MEM;
      else if (is_jump)  wb_sel = WB_PC4;
      else if (is_upper) wb_sel = WB_UPPER;
      else               wb_sel = WB_ALU;
    end
  end

  assign in_alu_phase = (state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB);

  assign bus.en_pc           = en_pc_d;
  assign bus.RegWrite        = reg_write_d;
  assign bus.Mem_read        = mem_read_d;
  assign bus.Mem_write       = mem_write_d;
  assign bus.AluSel          = in_alu_phase ? dec_op : ALU_ADD;
  assign bus.AluSrc          = in_alu_phase && !(is_op || is_branch);
  assign bus.sel_data_to_reg = wb_sel;
  assign bus.halted          = (state_q == ST_HALT);
  assign bus.trap            = (state_q == ST_TRAP);
  assign bus.retired         = retired_q;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Directed bench for rv32i_mc_ctrl: per-instruction expectations are queued
// when each instruction is driven and checked when its en_pc retires it.
module tb_rv32i_mc_ctrl;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32i_mc_ctrl_if #(.CNT_W(32)) bus ();

  rv32i_mc_ctrl #(.MEM_WAIT_EN(1'b1), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int cycles;
    int rw;
    int rd;
    int wr;
    int sel;
    int alusel;
    int alusrc;
    int retired;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_retired = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".en_pc"},    32'(bus.en_pc), 0);
    chk({tag, ".RegWrite"}, 32'(bus.RegWrite), 0);
    chk({tag, ".Mem_read"}, 32'(bus.Mem_read), 0);
    chk({tag, ".Mem_write"},32'(bus.Mem_write), 0);
    chk({tag, ".AluSel"},   32'(bus.AluSel), 0);
    chk({tag, ".AluSrc"},   32'(bus.AluSrc), 0);
    chk({tag, ".sel"},      32'(bus.sel_data_to_reg), 0);
    chk({tag, ".halted"},   32'(bus.halted), 0);
    chk({tag, ".trap"},     32'(bus.trap), 0);
    chk({tag, ".retired"},  bus.retired, 0);
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the next FETCH negedge.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int lows, input int e_cyc, input int e_rw,
                           input int e_sel, input int e_alusel, input int e_alusrc);
    exp_t e;
    int cyc = 0, rw = 0, rd = 0, wr = 0, both = 0, mem_seen = 0;
    int o_sel = 0, o_alusel = 0, o_alusrc = 0;
    bit done = 0;
    e.cycles = e_cyc; e.rw = e_rw; e.sel = e_sel; e.alusel = e_alusel; e.alusrc = e_alusrc;
    e.rd = (op == OPC_LOAD)  ? lows + 1 : 0;
    e.wr = (op == OPC_STORE) ? lows + 1 : 0;
    exp_retired++;
    e.retired = exp_retired;
    sb_q.push_back(e);

    bus.opcode = op; bus.funct3 = f3; bus.funct7_5 = f7;
    while (!done && cyc < 40) begin
      if (cyc == 1) begin
        bus.opcode = 7'($urandom); bus.funct3 = 3'($urandom); bus.funct7_5 = 1'($urandom);
      end
      if (bus.Mem_read || bus.Mem_write) begin
        mem_seen++;
        bus.mem_ready = (mem_seen > lows);
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      cyc++;
      rw += int'(bus.RegWrite);
      rd += int'(bus.Mem_read);
      wr += int'(bus.Mem_write);
      if (bus.Mem_read && bus.Mem_write) both++;
      if (bus.en_pc) begin
        done = 1;
        o_sel = int'(bus.sel_data_to_reg);
        o_alusel = int'(bus.AluSel);
        o_alusrc = int'(bus.AluSrc);
      end
      @(negedge clk);
    end

    e = sb_q.pop_front();
    chk({tag, ".retired_in_time"}, 32'(done), 1);
    chk({tag, ".cycles"}, cyc, e.cycles);
    chk({tag, ".RegWrite_pulses"}, rw, e.rw);
    chk({tag, ".Mem_read_cycles"}, rd, e.rd);
    chk({tag, ".Mem_write_cycles"}, wr, e.wr);
    chk({tag, ".strobes_exclusive"}, both, 0);
    if (e.sel >= 0)    chk({tag, ".sel_data_to_reg"}, o_sel, e.sel);
    if (e.alusel >= 0) chk({tag, ".AluSel"}, o_alusel, e.alusel);
    if (e.alusrc >= 0) chk({tag, ".AluSrc"}, o_alusrc, e.alusrc);
    chk({tag, ".retired"}, bus.retired, e.retired);
    $display("instr %s cycles=%0d regwrite=%0d rd=%0d wr=%0d retired=%0d",
             tag, cyc, rw, rd, wr, bus.retired);
  endtask

  // Drives an instruction that must end in HALT or TRAP, then resets out of it.
  task automatic run_stuck(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int e_trap, input int e_halt);
    int strobes = 0;
    bus.opcode = op; bus.funct3 = f3; bus.funct7_5 = f7;
    for (int i = 0; i < 24; i++) begin
      if (i == 1) begin
        bus.opcode = 7'($urandom); bus.funct3 = 3'($urandom); bus.funct7_5 = 1'($urandom);
      end
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      strobes += int'(bus.en_pc) + int'(bus.RegWrite) + int'(bus.Mem_read) + int'(bus.Mem_write);
      @(negedge clk);
    end
    chk({tag, ".trap"}, 32'(bus.trap), e_trap);
    chk({tag, ".halted"}, 32'(bus.halted), e_halt);
    chk({tag, ".no_strobes"}, strobes, 0);
    chk({tag, ".retired_frozen"}, bus.retired, exp_retired);
    $display("instr %s trap=%0d halted=%0d strobes=%0d", tag, bus.trap, bus.halted, strobes);
    reset = 1'b1;
    #1;
    chk_idle({tag, ".after_reset"});
    @(negedge clk);
    reset = 1'b0;
    exp_retired = 0;
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0; bus.mem_ready = 1'b0;
    #12;
    chk_idle("reset");
    @(negedge clk);
    reset = 1'b0;

    //         tag      opcode      f3      f7 lows cyc rw sel alu src
    run_instr("ADD",   OPC_OP,     3'b000, 0, 0,   4,  1, 1,  0,  0);
    run_instr("SUB",   OPC_OP,     3'b000, 1, 0,   4,  1, 1,  1,  0);
    run_instr("SRA",   OPC_OP,     3'b101, 1, 0,   4,  1, 1,  7,  0);
    run_instr("SLTU",  OPC_OP,     3'b011, 0, 0,   4,  1, 1,  4,  0);
    run_instr("SRAI",  OPC_OPIMM,  3'b101, 1, 0,   4,  1, 1,  7,  1);
    run_instr("ADDI7", OPC_OPIMM,  3'b000, 1, 0,   4,  1, 1,  0,  1);
    run_instr("SRLI",  OPC_OPIMM,  3'b101, 0, 0,   4,  1, 1,  6,  1);
    run_instr("LW",    OPC_LOAD,   3'b010, 0, 3,   8,  1, 0,  0,  1);
    run_instr("SW",    OPC_STORE,  3'b010, 0, 0,   4,  0, -1, 0,  1);
    run_instr("SW_W2", OPC_STORE,  3'b010, 0, 2,   6,  0, -1, 0,  1);
    run_instr("BEQ",   OPC_BRANCH, 3'b000, 0, 0,   3,  0, -1, 1,  0);
    run_instr("BNE",   OPC_BRANCH, 3'b001, 1, 0,   3,  0, -1, 1,  0);
    run_instr("JAL",   OPC_JAL,    3'b000, 0, 0,   4,  1, 2,  0,  1);
    run_instr("JALR",  OPC_JALR,   3'b000, 0, 0,   4,  1, 2,  0,  1);
    run_instr("LUI",   OPC_LUI,    3'b000, 0, 0,   3,  1, 3, -1, -1);
    run_instr("AUIPC", OPC_AUIPC,  3'b000, 0, 0,   3,  1, 3, -1, -1);

    // Reset in the middle of a stalled load.
    bus.opcode = OPC_LOAD; bus.funct3 = 3'b010; bus.funct7_5 = 1'b0; bus.mem_ready = 1'b0;
    for (int i = 0; i < 10 && !bus.Mem_read; i++) @(negedge clk);
    chk("lw_stall.Mem_read_high", 32'(bus.Mem_read), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("mid_mem_reset");
    @(negedge clk);
    reset = 1'b0;
    exp_retired = 0;
    $display("instr LW_RESET mem_read=%0d retired=%0d", bus.Mem_read, bus.retired);
    run_instr("ADD_POST", OPC_OP, 3'b000, 0, 0, 4, 1, 1, 0, 0);

    run_stuck("ILLEGAL_R", OPC_OP,     3'b001, 1, 1, 0);
    run_stuck("OPC_ZERO",  7'b0000000, 3'b000, 0, 1, 0);
    run_stuck("ECALL",     OPC_SYSTEM, 3'b000, 0, 0, 1);

    run_instr("XOR_END", OPC_OP, 3'b100, 0, 0, 4, 1, 1, 5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
